gs_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage GoldenSnitch RV32I core. It takes decoded control from ID, EX and MEM and produces per-stage enable and flush signals for the pipeline registers. It also runs the data-memory request handshake with a timeout FSM and keeps stall and flush performance counters. It sits beside the datapath and owns every pipeline-register write enable.

---
 rtl/gs_pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_gs_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gs_pipe_ctrl.sv
// Pipeline sequencing controller for the GoldenSnitch RV32I core: per-stage enables/flushes,
// data-memory request handshake with timeout, and stall/flush performance counters.
module gs_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic [1:0]       ex_pc_src,
  input  logic             ex_branch_taken,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             ex_redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state  | meaning
  // S_IDLE | no access outstanding; a MEM load/store issues its request here
  // S_WAIT | request held, waiting for dmem_ready while the timeout counter runs
  // S_ERR  | access timed out; request dropped and the MEM instruction retires as a NOP
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} mem_state_t;

  // The final WAIT cycle is the one where the incremented count would hit MEM_TIMEOUT-1.
  localparam logic [15:0] TO_LAST = (MEM_TIMEOUT > 1) ? 16'(MEM_TIMEOUT - 2) : 16'd0;

  mem_state_t  state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        err_set;
  logic        mem_stall, redir, lu_hz, f_stall, stall_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    err_set  = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = mem_read | mem_write;
        if (dmem_req && !dmem_ready) begin
          state_d  = S_WAIT;
          to_cnt_d = '0;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = S_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          err_set = 1'b1;
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!rst) dmem_req = 1'b0;
  end

  assign dmem_we   = dmem_req & mem_write;
  assign mem_stall = dmem_req & ~dmem_ready;
  assign redir     = (ex_pc_src == 2'b01) || (ex_pc_src == 2'b10) ||
                     (ex_pc_src == 2'b11 && ex_branch_taken);
  assign lu_hz     = ex_mem_read && (ex_rd_addr != 5'd0) &&
                     ((ex_rd_addr == id_rs1_addr) || (id_uses_rs2 && ex_rd_addr == id_rs2_addr));
  assign f_stall   = ~imem_ready;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    ex_redirect  = 1'b0;
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe frozen; WB takes a bubble so nothing retires twice.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redir) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_redirect = 1'b1;
    end else if (lu_hz) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (f_stall) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
    if (rst && state_q == S_ERR) mem_wb_flush = 1'b1;
  end

  assign stall_inc = (mem_stall | lu_hz | f_stall) & ~pc_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (err_set) mem_err <= 1'b1;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gs_pipe_ctrl.sv
// Scoreboard bench for gs_pipe_ctrl: directed test-plan scenarios then random traffic,
// checked against a pending-cycle reference model.
module tb_gs_pipe_ctrl;
  localparam int T  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic [1:0] ex_pc_src;
  logic mem_read, mem_write, imem_ready, dmem_ready;
  logic dmem_req, dmem_we, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, ex_redirect, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  gs_pipe_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_pc_src(ex_pc_src),
    .ex_branch_taken(ex_branch_taken), .mem_read(mem_read), .mem_write(mem_write),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .ex_redirect(ex_redirect), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0]   ctrl;  // pc,ifid,idex,exmem,memwb,f_ifid,f_idex,f_memwb,redirect,req,we
    logic          err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 0;

  // Reference model: an access's pending-cycle count, an error-retire flag, counters.
  int pend = 0;
  bit errph = 0;
  bit merr = 0;
  int sc = 0;
  int fc = 0;

  function automatic bit m_redir();
    return (ex_pc_src == 2'd1) || (ex_pc_src == 2'd2) || (ex_pc_src == 2'd3 && ex_branch_taken);
  endfunction

  function automatic bit m_luhz();
    return ex_mem_read && ex_rd_addr != 0 &&
           (ex_rd_addr == id_rs1_addr || (id_uses_rs2 && ex_rd_addr == id_rs2_addr));
  endfunction

  function automatic bit m_req();
    if (!rst || errph) return 1'b0;
    if (pend > 0) return 1'b1;
    return mem_read | mem_write;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit req, mst;
    bit pc, ifid, idex, exmem, memwb, fifid, fidex, fmemwb, rd;
    req = m_req();
    mst = req && !dmem_ready;
    {pc, ifid, idex, exmem, memwb} = 5'b11111;
    {fifid, fidex, fmemwb, rd} = 4'b0000;
    if (!rst) begin
      {pc, ifid, idex, exmem, memwb} = 5'b00000;
      {fifid, fidex, fmemwb} = 3'b111;
    end else if (mst) begin
      {pc, ifid, idex, exmem} = 4'b0000;
      fmemwb = 1'b1;
    end else if (m_redir()) begin
      fifid = 1'b1; fidex = 1'b1; rd = 1'b1;
    end else if (m_luhz()) begin
      pc = 1'b0; ifid = 1'b0; fidex = 1'b1;
    end else if (!imem_ready) begin
      pc = 1'b0; fifid = 1'b1;
    end
    if (rst && errph) fmemwb = 1'b1;
    e.ctrl = {pc, ifid, idex, exmem, memwb, fifid, fidex, fmemwb, rd, req, req & mem_write};
    e.err  = merr;
    e.sc   = CW'(sc);
    e.fc   = CW'(fc);
    return e;
  endfunction

  task automatic model_step();
    bit req, mst, pc, rd;
    exp_t e;
    e   = model_out();
    req = m_req();
    mst = req && !dmem_ready;
    pc  = e.ctrl[10];
    rd  = e.ctrl[2];
    if (!rst) begin
      pend = 0; errph = 0; merr = 0; sc = 0; fc = 0;
    end else begin
      if ((mst || m_luhz() || !imem_ready) && !pc && sc < CMAX) sc++;
      if (rd && fc < CMAX) fc++;
      if (errph) begin
        errph = 0; pend = 0;
      end else if (mst) begin
        pend++;
        if (pend == T) begin
          errph = 1; merr = 1; pend = 0;
        end
      end else begin
        pend = 0;
      end
    end
  endtask

  // Push the expectation for the current inputs, then advance one clock.
  task automatic apply();
    exp_q.push_back(model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic neutral();
    rst = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd_addr = 5'd0; ex_pc_src = 2'b00; ex_branch_taken = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got empty queue expected one entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ctrl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
                           id_ex_flush, mem_wb_flush, ex_redirect, dmem_req, dmem_we}), 32'(e.ctrl));
        check("mem_err", 32'(mem_err), 32'(e.err));
        check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        check("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    neutral();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pend = 0; errph = 0; merr = 0; sc = 0; fc = 0;
    running = 1;
    apply();                                   // forced outputs during reset

    // load-use: LOAD x5 in EX, ADD x6,x5,x1 in ID
    neutral(); ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_rs2_addr = 1; id_uses_rs2 = 1;
    apply();
    neutral(); apply();
    neutral(); ex_mem_read = 1; ex_rd_addr = 0; id_rs1_addr = 0; apply();   // x0 never hazards
    // JAL then untaken branch
    neutral(); ex_pc_src = 2'b01; apply();
    neutral(); ex_pc_src = 2'b11; ex_branch_taken = 0; apply();
    // redir and load-use together: redirect wins
    neutral(); ex_pc_src = 2'b10; ex_mem_read = 1; ex_rd_addr = 1; apply();
    // STORE with 3 wait cycles while a taken branch sits in EX
    for (int i = 0; i < 4; i++) begin
      neutral(); mem_write = 1; ex_pc_src = 2'b11; ex_branch_taken = 1; dmem_ready = (i == 3);
      apply();
    end
    neutral(); apply();
    // LOAD that never gets dmem_ready
    for (int i = 0; i < 7; i++) begin
      neutral(); mem_read = (i < T + 1); dmem_ready = 0; apply();
    end
    // dmem_ready in the timeout cycle counts as success
    for (int i = 0; i < T; i++) begin
      neutral(); mem_read = 1; dmem_ready = (i == T - 1); apply();
    end
    // reset pulse in the middle of a wait
    for (int i = 0; i < 6; i++) begin
      neutral(); mem_read = 1; dmem_ready = (i == 5); rst = (i != 2); apply();
    end
    // fetch stall, then flush counter saturation
    neutral(); imem_ready = 0; apply();
    for (int i = 0; i < CMAX + 3; i++) begin
      neutral(); ex_pc_src = 2'b01; apply();
    end

    for (int n = 0; n < 3000; n++) begin
      int op;
      rst             = ($urandom_range(0, 199) != 0);
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_rd_addr      = 5'($urandom_range(0, 3));
      ex_pc_src       = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ex_branch_taken = 1'($urandom_range(0, 1));
      op              = $urandom_range(0, 3);
      mem_read        = (op == 0);
      mem_write       = (op == 1);
      imem_ready      = ($urandom_range(0, 4) != 0);
      dmem_ready      = ($urandom_range(0, 9) < 6);
      apply();
    end

    running = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
